// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default address width and Gray-code pointer helpers.
package fifo_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 3;
  localparam int unsigned GRAY_MAX_W     = 32;

  // Callers widen to GRAY_MAX_W and truncate the result back to pointer width.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
module ptr_sync_2ff #(
  parameter int unsigned W = 4
) (
  input  logic         wclk,
  input  logic         wrst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side controller of an async FIFO: pointers, full/level flags, sticky overflow.
module fifo_write_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
  parameter int unsigned AF_MARGIN = 1
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              wr_valid,
  input  logic              ovf_clr,
  input  logic [ADDR_W:0]   g_rd_ptr_async,
  output logic              wr_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W:0]   b_wr_ptr,
  output logic [ADDR_W:0]   g_wr_ptr,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
);

  localparam int unsigned PW    = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  // Full when the two MSBs of the Gray pointers differ and the rest match.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
  localparam logic [PW-1:0] AF_LEVEL  = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] b_wr_ptr_q, b_wr_ptr_d;
  logic [PW-1:0] g_wr_ptr_q, g_wr_ptr_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] g_rd_ptr_sync;
  logic [PW-1:0] b_rd_ptr_sync;
  logic          full_c;
  logic          accept_c;

  ptr_sync_2ff #(.W(PW)) u_rd_sync (
    .wclk (wclk),
    .wrst (wrst),
    .d    (g_rd_ptr_async),
    .q    (g_rd_ptr_sync)
  );

  assign full_c        = ((g_wr_ptr_q ^ g_rd_ptr_sync) == FULL_MASK);
  assign accept_c      = wr_valid & ~full_c & ~wrst;
  assign b_rd_ptr_sync = PW'(gray2bin(GRAY_MAX_W'(g_rd_ptr_sync)));

  // Next-state: advance both pointers together so the Gray copy never lags.
  always_comb begin
    b_wr_ptr_d = b_wr_ptr_q;
    g_wr_ptr_d = g_wr_ptr_q;
    ovf_d      = ovf_q;
    if (accept_c) begin
      b_wr_ptr_d = b_wr_ptr_q + PW'(1);
      g_wr_ptr_d = PW'(bin2gray(GRAY_MAX_W'(b_wr_ptr_d)));
    end
    if (wr_valid && full_c) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      b_wr_ptr_q <= '0;
      g_wr_ptr_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      b_wr_ptr_q <= b_wr_ptr_d;
      g_wr_ptr_q <= g_wr_ptr_d;
      ovf_q      <= ovf_d;
    end
  end

  assign mem_we      = accept_c;
  assign mem_waddr   = b_wr_ptr_q[ADDR_W-1:0];
  assign b_wr_ptr    = b_wr_ptr_q;
  assign g_wr_ptr    = g_wr_ptr_q;
  assign full        = full_c;
  assign wr_ready    = ~full_c;
  assign wr_level    = b_wr_ptr_q - b_rd_ptr_sync;
  assign almost_full = full_c | (wr_level >= AF_LEVEL);
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Scoreboard bench for fifo_write_ctrl against an occupancy-count reference model.
module tb_fifo_write_ctrl;

  logic       wclk;
  logic       wrst;
  logic       wr_valid;
  logic       ovf_clr;
  logic [3:0] g_rd_ptr_async;
  logic       wr_ready;
  logic       mem_we;
  logic [2:0] mem_waddr;
  logic [3:0] b_wr_ptr;
  logic [3:0] g_wr_ptr;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic       overflow;

  fifo_write_ctrl #(.ADDR_W(3), .AF_MARGIN(1)) dut (
    .wclk           (wclk),
    .wrst           (wrst),
    .wr_valid       (wr_valid),
    .ovf_clr        (ovf_clr),
    .g_rd_ptr_async (g_rd_ptr_async),
    .wr_ready       (wr_ready),
    .mem_we         (mem_we),
    .mem_waddr      (mem_waddr),
    .b_wr_ptr       (b_wr_ptr),
    .g_wr_ptr       (g_wr_ptr),
    .full           (full),
    .almost_full    (almost_full),
    .wr_level       (wr_level),
    .overflow       (overflow)
  );

  typedef struct {
    logic       we;
    logic [2:0] waddr;
    logic [3:0] bptr;
    logic [3:0] gptr;
    logic [3:0] level;
    logic       full;
    logic       af;
    logic       ready;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: counts, not pointers. Read counter sync is a 2-deep history.
  int   m_wr   = 0;
  int   m_rd   = 0;
  int   m_s1   = 0;
  int   m_s2   = 0;
  bit   m_ovf  = 0;

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [3:0] to_gray(input int v);
    logic [3:0] b;
    b = 4'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, publish expected outputs, then advance the model on the edge.
  task automatic step(input bit r, input bit v, input bit c, input bit chk);
    int   occ;
    bit   f;
    exp_t e;
    wrst           = r;
    wr_valid       = v;
    ovf_clr        = c;
    g_rd_ptr_async = to_gray(m_rd);
    occ = (m_wr - m_s2) & 15;
    f   = (occ == 8);
    e.we    = v && !f && !r;
    e.waddr = 3'(m_wr % 8);
    e.bptr  = 4'(m_wr);
    e.gptr  = to_gray(m_wr);
    e.level = 4'(occ);
    e.full  = f;
    e.af    = (occ >= 7);
    e.ready = !f;
    e.ovf   = m_ovf;
    if (chk) exp_q.push_back(e);
    @(posedge wclk);
    #1;
    if (r) begin
      m_wr = 0; m_s1 = 0; m_s2 = 0; m_ovf = 0; m_rd = 0;
    end else begin
      if (v && !f) m_wr = (m_wr + 1) % 16;
      m_ovf = (v && f) || (m_ovf && !c);
      m_s2  = m_s1;
      m_s1  = m_rd;
    end
  endtask

  // Reader that never passes the writer; moves with probability pct/100.
  task automatic read_maybe(input int pct);
    if (m_rd != m_wr && int'($urandom_range(99)) < pct) m_rd = (m_rd + 1) % 16;
  endtask

  // Monitor: pops one expectation per cycle and compares every output.
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mem_we",      int'(mem_we),      int'(e.we));
        check("mem_waddr",   int'(mem_waddr),   int'(e.waddr));
        check("b_wr_ptr",    int'(b_wr_ptr),    int'(e.bptr));
        check("g_wr_ptr",    int'(g_wr_ptr),    int'(e.gptr));
        check("wr_level",    int'(wr_level),    int'(e.level));
        check("full",        int'(full),        int'(e.full));
        check("almost_full", int'(almost_full), int'(e.af));
        check("wr_ready",    int'(wr_ready),    int'(e.ready));
        check("overflow",    int'(overflow),    int'(e.ovf));
      end
    end
  end

  initial begin
    int guard;
    wrst = 1'b1; wr_valid = 1'b0; ovf_clr = 1'b0; g_rd_ptr_async = '0;
    @(posedge wclk);
    #1;
    step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    step(0, 0, 0, 1);
    // Fill from empty, then keep pushing into a full FIFO.
    for (int i = 0; i < 12; i++) step(0, 1, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    // One read becomes visible after the synchroniser delay.
    m_rd = 1;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    // Streaming with a tightly following reader exercises pointer wrap.
    for (int i = 0; i < 60; i++) begin
      step(0, 1, 0, 1);
      read_maybe(100);
    end
    // Mid-stream reset with a write request pending.
    step(1, 1, 0, 1);
    step(0, 1, 0, 1);
    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      bit r, v, c;
      r = ($urandom_range(99) == 0);
      v = ($urandom_range(3) != 0);
      c = ($urandom_range(15) == 0);
      step(r, v, c, 1);
      read_maybe((i / 100) % 2 == 0 ? 30 : 70);
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge wclk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_write_ctrl.md
FIFO_WRITE_CTRL -- requirements
Module: fifo_write_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 3: memory address width; FIFO DEPTH = 2**ADDR_W; pointer width PW = ADDR_W+1.
REQ-002 SHALL have parameter AF_MARGIN, default 1: almost_full asserts when free slots <= AF_MARGIN.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 wclk  in  1  write-domain clock; all state on rising edge.
REQ-005 wrst  in  1  synchronous active-high reset.
REQ-006 wr_valid  in  1  producer write request, data on memory port same cycle.
REQ-007 ovf_clr  in  1  clears sticky overflow.
REQ-008 g_rd_ptr_async  in  PW  Gray read pointer from read domain, unsynchronised.
REQ-009 wr_ready  out  1  = ~full.
REQ-010 mem_we  out  1  memory write strobe.
REQ-011 mem_waddr  out  ADDR_W  memory write address.
REQ-012 b_wr_ptr  out  PW  binary write pointer, registered.
REQ-013 g_wr_ptr  out  PW  Gray write pointer, registered, to read domain.
REQ-014 full  out  1  FIFO full.
REQ-015 almost_full  out  1  FIFO nearly full.
REQ-016 wr_level  out  PW  occupancy as seen by write domain, 0..DEPTH.
REQ-017 overflow  out  1  sticky: write attempted while full.

Function
REQ-018 accept = wr_valid & ~full & ~wrst; mem_we SHALL equal accept, combinationally; mem_waddr = b_wr_ptr[ADDR_W-1:0].
REQ-019 On accept, b_wr_ptr <= b_wr_ptr+1 and g_wr_ptr <= bin2gray(b_wr_ptr+1) on the same edge; g_wr_ptr SHALL never lag b_wr_ptr.
REQ-020 Pointers SHALL wrap modulo 2**PW (e.g. 4'b1111 -> 4'b0000) with no special handling.
REQ-021 g_rd_ptr_async SHALL pass through a 2-flop synchroniser to give g_rd_ptr_sync; latency exactly 2 wclk edges.
REQ-022 full SHALL be combinational: g_wr_ptr == {~g_rd_ptr_sync[PW-1:PW-2], g_rd_ptr_sync[PW-3:0]}.
REQ-023 wr_level = (b_wr_ptr - gray2bin(g_rd_ptr_sync)) mod 2**PW, combinational from registered values.
REQ-024 almost_full = (wr_level >= DEPTH-AF_MARGIN); full implies almost_full.
REQ-025 overflow SHALL set on the edge after wr_valid & full; it stays set until ovf_clr or wrst; if set and clear coincide, set wins.
REQ-026 full/level SHALL be pessimistic: reads become visible only after synchroniser latency; no write is ever accepted into an occupied slot.
REQ-027 Pointers SHALL not change when wr_valid is low or full is high.

Reset
REQ-028 On wrst high at a wclk edge: b_wr_ptr, g_wr_ptr, both synchroniser stages and overflow SHALL become 0; mem_we SHALL be 0 during any cycle where wrst is high.
REQ-029 After reset with g_rd_ptr_async = 0: full=0, almost_full=0, wr_level=0, wr_ready=1.
REQ-030 Reset mid-operation SHALL discard write-side state immediately; read side SHALL be reset by the system in the same window.

Structure
REQ-031 Package fifo_pkg SHALL hold the ADDR_W default and functions bin2gray and gray2bin.
REQ-032 Synchroniser SHALL be a sub-module ptr_sync_2ff (parameter W, wclk, wrst, d, q); the read side reuses it.

Verification
REQ-033 Reset, g_rd_ptr_async=0, wr_valid high 9 cycles -> mem_waddr 0..7, g_wr_ptr 1,3,2,6,7,5,4,12; full=1 after 8th accept with b_wr_ptr=4'b1000, wr_level=8; 9th request: mem_we=0.
REQ-034 From full, hold wr_valid -> overflow=1 next edge, remains 1; pulse ovf_clr -> overflow=0 next edge.
REQ-035 From full, set g_rd_ptr_async=4'b0001 -> full stays 1 for 2 edges, then full=0, wr_level=7, wr_ready=1.
REQ-036 Continuous writes with g_rd_ptr_async following -> b_wr_ptr wraps 4'b1111->4'b0000, g_wr_ptr 4'b1000->4'b0000, no spurious full.
REQ-037 AF_MARGIN=1: almost_full rises when wr_level reaches 7, before full.
REQ-038 Mid-stream wrst high one cycle with wr_valid high -> mem_we=0 that cycle; next cycle b_wr_ptr=0, g_wr_ptr=0, overflow=0.
